// File: rtl/dec_ctrl_pkg.sv
// Shared definitions for the ADC decimation-chain sequencer.
//   state_e   : sequencer state encoding, also exported on the debug state port
//   DW_DEF    : default sample width (HB2 dat_out)
//   CNT_W_DEF : default width of the settle/capture counters
package dec_ctrl_pkg;

    localparam int DW_DEF    = 35;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4
    } state_e;

endpackage

// File: rtl/dec_sample_fifo.sv
// Small synchronous sample FIFO with a valid/ready read side.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset (contents cleared)
//   push       : write push_dat; taken when not full, or when full and a pop
//                happens in the same cycle
//   push_dat   : sample to write
//   full/empty : occupancy flags, derived from registered pointers only
//   m_vld      : head entry valid (== !empty)
//   m_rdy      : consumer ready; a pop happens when m_vld && m_rdy
//   m_dat      : head entry, stable while m_vld && !m_rdy
// Handshake: a sample transfers on every cycle where m_vld and m_rdy are
// both high at the clock edge; m_vld never depends combinationally on m_rdy.
module dec_sample_fifo #(
    parameter int DW    = 35,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    output logic          full,
    output logic          m_vld,
    input  logic          m_rdy,
    output logic [DW-1:0] m_dat,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic pop;
    logic push_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign m_vld   = !empty;
    assign m_dat   = mem_q[rd_ptr_q[AW-1:0]];
    assign pop     = m_vld && m_rdy;
    // A pop frees the head slot at the same edge, so full+pop still accepts.
    assign push_ok = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/dec_chain_ctrl.sv
// Sequencer for the ADC decimation chain (CIC -> comp -> HB1 -> HB2).
// Holds the chain in reset while idle, flushes it on start, discards the
// start-up transient, captures samples into a small output FIFO.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   start, stop        : single-cycle requests (stop wins on collision)
//   cfg_settle_cnt     : HB2 strobes to discard, latched at start
//   cfg_cap_len        : strobes to capture (0 = until stop), latched at start
//   chain_rstn         : active-low reset to every filter
//   chain_vld/chain_dat: HB2 output strobe and sample
//   m_vld/m_rdy/m_dat  : output stream, valid/ready
//   busy, done, ovf    : status (done is a one-cycle pulse, ovf is sticky)
//   state              : debug view of the sequencer state
module dec_chain_ctrl
    import dec_ctrl_pkg::*;
#(
    parameter int DW           = DW_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int FIFO_DEPTH   = 4,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_settle_cnt,
    input  logic [CNT_W-1:0] cfg_cap_len,
    output logic             chain_rstn,
    input  logic             chain_vld,
    input  logic [DW-1:0]    chain_dat,
    output logic             m_vld,
    input  logic             m_rdy,
    output logic [DW-1:0]    m_dat,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [2:0]       state
);

    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);

    state_e           state_q, state_d;
    logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
    logic [CNT_W-1:0] settle_lat_q, settle_lat_d;
    logic [CNT_W-1:0] cap_len_q, cap_len_d;
    logic             ovf_q, ovf_d;
    logic             done_q, busy_q, chain_rstn_q;

    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CNT_W-1:0] settle_inc;
    logic [CNT_W-1:0] cap_inc;

    // Saturating increments: counters stick at all-ones instead of wrapping.
    assign settle_inc = (settle_cnt_q == '1) ? settle_cnt_q : settle_cnt_q + CNT_W'(1);
    assign cap_inc    = (cap_cnt_q == '1)    ? cap_cnt_q    : cap_cnt_q + CNT_W'(1);
    assign fifo_pop   = m_vld && m_rdy;

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        settle_cnt_d = settle_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        settle_lat_d = settle_lat_q;
        cap_len_d    = cap_len_q;
        ovf_d        = ovf_q;
        fifo_push    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    settle_lat_d = cfg_settle_cnt;
                    cap_len_d    = cfg_cap_len;
                    flush_cnt_d  = '0;
                    settle_cnt_d = '0;
                    cap_cnt_d    = '0;
                    ovf_d        = 1'b0;
                    state_d      = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (stop) begin
                    state_d = ST_DRAIN;
                end else if (flush_cnt_q == FL_W'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_SETTLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FL_W'(1);
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    state_d = ST_DRAIN;
                end else if (settle_lat_q == '0) begin
                    state_d = ST_RUN;
                end else if (chain_vld) begin
                    // The strobe that reaches the settle count is still discarded.
                    settle_cnt_d = settle_inc;
                    if (settle_inc >= settle_lat_q) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A strobe in the stop cycle is still captured.
                if (chain_vld) begin
                    cap_cnt_d = cap_inc;
                    if (fifo_full && !fifo_pop) ovf_d     = 1'b1;
                    else                        fifo_push = 1'b1;
                end
                if (stop) begin
                    state_d = ST_DRAIN;
                end else if (chain_vld && (cap_len_q != '0) && (cap_inc >= cap_len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            flush_cnt_q  <= '0;
            settle_cnt_q <= '0;
            cap_cnt_q    <= '0;
            settle_lat_q <= '0;
            cap_len_q    <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            chain_rstn_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            settle_lat_q <= settle_lat_d;
            cap_len_q    <= cap_len_d;
            ovf_q        <= ovf_d;
            // Status outputs are registered from the next state so they line
            // up with the state they describe.
            done_q       <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
            chain_rstn_q <= (state_d == ST_SETTLE) || (state_d == ST_RUN);
        end
    end

    dec_sample_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (fifo_push),
        .push_dat (chain_dat),
        .full     (fifo_full),
        .m_vld    (m_vld),
        .m_rdy    (m_rdy),
        .m_dat    (m_dat),
        .empty    (fifo_empty)
    );

    assign chain_rstn = chain_rstn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ovf        = ovf_q;
    assign state      = state_q;

endmodule

// File: tb/tb_dec_chain_ctrl.sv
// Bench for dec_chain_ctrl: directed scenarios plus randomized traffic,
// every cycle checked against a queue-based behavioural model.
module tb_dec_chain_ctrl;

    localparam int DW    = 35;
    localparam int CNT_W = 16;
    localparam int DEPTH = 4;
    localparam int FLUSH = 16;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rstn;
    logic             start, stop;
    logic [CNT_W-1:0] cfg_settle_cnt, cfg_cap_len;
    logic             chain_rstn;
    logic             chain_vld;
    logic [DW-1:0]    chain_dat;
    logic             m_vld, m_rdy;
    logic [DW-1:0]    m_dat;
    logic             busy, done, ovf;
    logic [2:0]       state;

    always #5 clk = ~clk;

    dec_chain_ctrl #(
        .DW(DW), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop),
        .cfg_settle_cnt(cfg_settle_cnt), .cfg_cap_len(cfg_cap_len),
        .chain_rstn(chain_rstn), .chain_vld(chain_vld), .chain_dat(chain_dat),
        .m_vld(m_vld), .m_rdy(m_rdy), .m_dat(m_dat),
        .busy(busy), .done(done), .ovf(ovf), .state(state)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 flush, 2 settle, 3 run, 4 drain
    int               md_phase, md_flush, md_seen, md_cap;
    logic [CNT_W-1:0] md_s, md_l;
    bit               md_ovf, md_done;
    logic [DW-1:0]    mq[$];

    task automatic model_reset();
        md_phase = 0; md_flush = 0; md_seen = 0; md_cap = 0;
        md_s = '0; md_l = '0; md_ovf = 0; md_done = 0;
        mq.delete();
    endtask

    task automatic model_step();
        bit pop, full, push;
        pop  = (mq.size() > 0) && m_rdy;
        full = (mq.size() == DEPTH);
        push = 0;
        md_done = 0;
        case (md_phase)
            0: if (start && !stop) begin
                md_s = cfg_settle_cnt; md_l = cfg_cap_len; md_ovf = 0;
                md_flush = 0; md_seen = 0; md_cap = 0; md_phase = 1;
            end
            1: if (stop) md_phase = 4;
               else begin
                   md_flush++;
                   if (md_flush == FLUSH) md_phase = 2;
               end
            2: if (stop) md_phase = 4;
               else if (md_s == 0) md_phase = 3;
               else if (chain_vld) begin
                   md_seen++;
                   if (md_seen == int'(md_s)) md_phase = 3;
               end
            3: begin
                if (chain_vld) begin
                    md_cap++;
                    if (full && !pop) md_ovf = 1;
                    else              push = 1;
                end
                if (stop) md_phase = 4;
                else if (md_l != 0 && md_cap == int'(md_l)) md_phase = 4;
            end
            4: if (mq.size() == 0) begin md_phase = 0; md_done = 1; end
            default: md_phase = 0;
        endcase
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(chain_dat);
    endtask

    task automatic check_outs();
        chk("state", state, md_phase);
        chk("busy", busy, md_phase != 0);
        chk("chain_rstn", chain_rstn, (md_phase == 2) || (md_phase == 3));
        chk("done", done, md_done);
        chk("ovf", ovf, md_ovf);
        chk("m_vld", m_vld, mq.size() != 0);
        if (mq.size() != 0) chk("m_dat", m_dat, mq[0]);
    endtask

    // ---------------- driver ----------------
    bit            rdy_v;
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_q[$];

    task automatic tick(input bit st, input bit sp, input bit v, input logic [DW-1:0] d);
        @(negedge clk);
        start = st; stop = sp; chain_vld = v; chain_dat = d; m_rdy = rdy_v;
        if (m_vld && m_rdy) got.push_back(m_dat);
        @(posedge clk);
        model_step();
        #1;
        check_outs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, '0);
    endtask

    // start, then sit through flush and one settle cycle
    task automatic start_run(input int s, input int l);
        cfg_settle_cnt = CNT_W'(s);
        cfg_cap_len    = CNT_W'(l);
        tick(1, 0, 0, '0);
        idle(FLUSH + 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (md_phase != 0 && n < budget) begin
            tick(0, 0, 0, '0);
            n++;
        end
        chk("wait_idle_busy", busy, 0);
    endtask

    task automatic score(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk(tag, got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn = 1'b1; start = 0; stop = 0; chain_vld = 0; chain_dat = '0; m_rdy = 0;
        cfg_settle_cnt = '0; cfg_cap_len = '0; rdy_v = 0;
        model_reset();
        #2 rstn = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_chain_rstn", chain_rstn, 0);
        chk("rst_m_vld", m_vld, 0);
        chk("rst_m_dat", m_dat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;

        // basic capture: 3 discarded, 4..8 delivered
        rdy_v = 1;
        start_run(3, 5);
        for (int i = 1; i <= 10; i++) begin
            tick(0, 0, 1, DW'(i));
            idle(7);
        end
        wait_idle(40);
        for (int i = 4; i <= 8; i++) exp_q.push_back(DW'(i));
        score("basic");
        chk("basic_ovf", ovf, 0);

        // backpressure overflow
        rdy_v = 0;
        start_run(0, 8);
        for (int i = 1; i <= 8; i++) begin
            tick(0, 0, 1, DW'(i));
            idle(1);
        end
        chk("bp_ovf", ovf, 1);
        chk("bp_head", m_dat, 1);
        chk("bp_state_drain", state, 4);
        rdy_v = 1;
        wait_idle(20);
        for (int i = 1; i <= 4; i++) exp_q.push_back(DW'(i));
        score("bp");

        // full plus pop in the same cycle
        rdy_v = 0;
        start_run(0, 5);
        for (int i = 1; i <= 4; i++) tick(0, 0, 1, DW'(i));
        rdy_v = 1;
        tick(0, 0, 1, DW'(5));
        chk("fullpop_ovf", ovf, 0);
        wait_idle(20);
        for (int i = 1; i <= 5; i++) exp_q.push_back(DW'(i));
        score("fullpop");

        // continuous capture ended by stop with a strobe
        rdy_v = 1;
        start_run(0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick(0, 0, 1, DW'(i));
            idle(2);
        end
        tick(0, 1, 1, DW'(21));
        chk("cont_rstn_after_stop", chain_rstn, 0);
        wait_idle(20);
        for (int i = 1; i <= 21; i++) exp_q.push_back(DW'(i));
        score("cont");

        // stop in flush
        cfg_settle_cnt = '0; cfg_cap_len = CNT_W'(3);
        tick(1, 0, 0, '0);
        idle(4);
        tick(0, 1, 0, '0);
        chk("flushstop_drain", state, 4);
        tick(0, 0, 0, '0);
        chk("flushstop_done", done, 1);
        tick(0, 0, 0, '0);
        chk("flushstop_busy", busy, 0);
        score("flushstop");

        // start and stop together in idle
        tick(1, 1, 0, '0);
        chk("collide_busy", busy, 0);
        idle(2);

        // async reset in run with 3 samples queued
        rdy_v = 0;
        start_run(0, 0);
        for (int i = 1; i <= 3; i++) tick(0, 0, 1, DW'(100 + i));
        chk("arst_pre_vld", m_vld, 1);
        #3 rstn = 1'b0;
        #1;
        model_reset();
        chk("arst_m_vld", m_vld, 0);
        chk("arst_chain_rstn", chain_rstn, 0);
        chk("arst_state", state, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1;
        chk("arst_no_done", done, 0);
        @(negedge clk) rstn = 1'b1;
        got.delete();
        idle(2);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit st, sp, v;
            logic [63:0] r;
            st = ($urandom_range(0, 9) == 0);
            sp = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 2) == 0);
            rdy_v = ($urandom_range(0, 1) == 0);
            cfg_settle_cnt = CNT_W'($urandom_range(0, 4));
            cfg_cap_len    = CNT_W'($urandom_range(0, 9));
            r = {$urandom(), $urandom()};
            tick(st, sp, v, r[DW-1:0]);
        end
        rdy_v = 1;
        tick(0, 1, 0, '0);
        wait_idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/dec_chain_ctrl.md
Name: dec_chain_ctrl

Overview:
Sequencer for the ADC decimation chain (CIC -> CIC compensation -> HB1 -> HB2). It holds the chain in reset when idle and flushes it on start. It then discards the filter start-up transient for a programmable number of HB2 output strobes and captures a programmable number of samples. Captured samples go into a small FIFO with a valid/ready output, for a downstream consumer such as a DMA or capture RAM.

Parameters:
DW, 35, sample width (matches HB2 dat_out)
CNT_W, 16, width of settle/capture counters
FIFO_DEPTH, 4, output FIFO entries (power of 2)
FLUSH_CYCLES, 16, minimum clk cycles chain_rstn held low after start

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle start request
stop  in  1  single-cycle abort request
cfg_settle_cnt  in  CNT_W  HB2 strobes to discard before capture; sampled at start
cfg_cap_len  in  CNT_W  strobes to capture; 0 = continuous until stop; sampled at start
chain_rstn  out  1  active-low reset driven to every filter rstn
chain_vld  in  1  HB2 clk_vld_out strobe
chain_dat  in  DW  HB2 dat_out, signed
m_vld  out  1  output sample valid
m_rdy  in  1  consumer ready
m_dat  out  DW  output sample, signed, unmodified
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on return to IDLE
ovf  out  1  sticky: sample dropped on full FIFO; cleared on accepted start
state  out  3  debug: IDLE=0 FLUSH=1 SETTLE=2 RUN=3 DRAIN=4

Behaviour:
- Reset values: chain_rstn=0, m_vld=0, m_dat=0, busy=0, done=0, ovf=0, state=IDLE, FIFO empty, all counters 0. Every output is registered.
- IDLE:
  - chain_rstn=0.
  - start=1 and stop=0: latch cfg_settle_cnt and cfg_cap_len, clear ovf, go to FLUSH.
  - start and stop together: stop wins, stay in IDLE.
- FLUSH:
  - chain_rstn=0 for exactly FLUSH_CYCLES cycles, then go to SETTLE.
  - chain_rstn goes high on the first SETTLE cycle.
- SETTLE:
  - chain_rstn=1. Each chain_vld increments settle_cnt and the sample is discarded.
  - When settle_cnt reaches the latched settle count, go to RUN. The strobe that hits the count is discarded.
  - If the latched settle count is 0, SETTLE lasts 1 cycle and no strobe is discarded.
- RUN:
  - Each chain_vld pushes chain_dat into the FIFO and increments cap_cnt.
  - If the FIFO is full with no pop that cycle: drop the sample, set ovf, and still increment cap_cnt.
  - A push and a pop in the same cycle on a full FIFO is accepted; ovf is not set.
  - If cap_len != 0 and cap_cnt reaches cap_len, go to DRAIN. The strobe reaching cap_len is pushed.
  - If cap_len == 0, capture is continuous until stop.
- DRAIN:
  - chain_rstn=0. chain_vld is ignored.
  - When the FIFO is empty, pulse done for 1 cycle and go to IDLE.
- stop in FLUSH, SETTLE or RUN: go to DRAIN next cycle. A chain_vld in the stop cycle in RUN is still pushed.
- stop in DRAIN is ignored. start while busy is ignored.
- Output FIFO:
  - Standard valid/ready: a pop occurs when m_vld and m_rdy are both high.
  - m_dat is held stable while m_vld=1 and m_rdy=0.
  - A push in cycle N appears on m_vld/m_dat in cycle N+1 at the earliest.
  - Order is preserved.
- Counters saturate and never wrap; cap_len=0 suppresses the compare.
- Asynchronous reset mid-operation: all state returns to reset values immediately. FIFO contents are lost, chain_rstn=0, and no done pulse is issued.

Decomposition:
- Package dec_ctrl_pkg holds:
  - state_e enum with the encoding above
  - DW_DEF=35
  - CNT_W_DEF=16
- Sub-module dec_sample_fifo:
  - synchronous FIFO, DW x FIFO_DEPTH
  - ports: push, push_dat, full, m_vld, m_rdy, m_dat, empty
  - pointers carry an extra wrap bit
- FSM, counters and ovf logic live in dec_chain_ctrl.

Test Plan:
- Basic capture: settle=3, cap_len=5, m_rdy=1, chain_vld every 8 clk with dat=1..10.
  - chain_rstn low for 16 clk after start.
  - Samples 4..8 are emitted in order, then one done pulse.
  - busy=0 and ovf=0 at the end.
- Backpressure overflow: settle=0, cap_len=8, m_rdy=0 throughout, dat=1..8.
  - FIFO holds 1..4 and ovf=1.
  - Releasing m_rdy yields exactly 1..4, then done.
- Full plus pop: FIFO full and a strobe with m_rdy=1 in the same cycle.
  - The strobe is accepted and ovf stays 0.
- Continuous and stop: cap_len=0, 20 strobes, then stop together with a strobe.
  - All 21 samples are delivered.
  - chain_rstn=0 the next cycle, done after the FIFO drains.
- Stop in FLUSH and start/stop collision:
  - stop 5 cycles after start gives DRAIN, then done 2 cycles later with zero samples.
  - start and stop together in IDLE: busy stays 0.
- Async reset in RUN with 3 samples queued.
  - Immediately m_vld=0, chain_rstn=0, state=IDLE, and no done pulse.
